// File: rtl/dm_pkg.sv
// Shared state encoding and AXI/beat constants for the datamover responders.
// Latency: none (declarations only).
// Backpressure: not applicable.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        DONE = 2'd3
    } dm_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         BEAT_BYTES     = 128;
    localparam int         BEAT_SHIFT     = $clog2(BEAT_BYTES);
    localparam int         BOUNDARY_4K    = 4096;

    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/dm_rd_responder_if.sv
// AXI4 read address/data channels between a datamover responder and DDR4.
// Latency: none (wires only).
// Backpressure: standard AXI valid/ready on AR and R.
interface dm_rd_responder_if #(
    parameter int AXI_ADDR_WIDTH  = 36,
    parameter int BRAM_DATA_WIDTH = 1024,
    parameter int AXI_ID_WIDTH    = 4
);
    logic                       arvalid;
    logic                       arready;
    logic [AXI_ADDR_WIDTH-1:0]  araddr;
    logic [7:0]                 arlen;
    logic [2:0]                 arsize;
    logic [1:0]                 arburst;
    logic [AXI_ID_WIDTH-1:0]    arid;
    logic                       rvalid;
    logic                       rready;
    logic [BRAM_DATA_WIDTH-1:0] rdata;
    logic [1:0]                 rresp;
    logic                       rlast;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arid, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/dm_burst_calc.sv
// Burst sizing: arlen = min(beats left, MAX_BURST_LEN, beats to next 4 KB) - 1.
// Latency: combinational.
// Backpressure: none.
module dm_burst_calc
    import dm_pkg::*;
#(
    parameter int BEATS_WIDTH   = 8,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [BEATS_WIDTH-1:0] beats_rem_i,
    input  logic [11:0]            addr_lo_i,
    output logic [7:0]             arlen_o
);

    logic [31:0] to_4k_beats;
    logic [31:0] lim;

    always_comb begin
        to_4k_beats = (32'(BOUNDARY_4K) - 32'(addr_lo_i)) >> BEAT_SHIFT;
        lim         = 32'(beats_rem_i);
        if (lim > 32'(MAX_BURST_LEN)) begin
            lim = 32'(MAX_BURST_LEN);
        end
        if (lim > to_4k_beats) begin
            lim = to_4k_beats;
        end
        // Degenerate inputs still produce a legal single-beat burst.
        if (lim == 32'd0) begin
            lim = 32'd1;
        end
        arlen_o = 8'(lim - 32'd1);
    end

endmodule

// File: rtl/dm_rd_responder.sv
// Load responder: one command -> AXI4 INCR read bursts -> BRAM writes, then done/err pulse.
// Latency: BRAM write 1 cycle after each R beat; done_o coincides with the last write.
// Backpressure: cmd_ready_o low while busy; rready held high in R (BRAM never stalls). DM_RD_PERF_CNT_EN adds perf_cycles_o.
module dm_rd_responder
    import dm_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH   = 36,
    parameter int BRAM_ADDR_WIDTH  = 10,
    parameter int BRAM_DATA_WIDTH  = 1024,
    parameter int BYTE_TRANS_WIDTH = 15,
    parameter int AXI_ID_WIDTH     = 4,
    parameter int MAX_BURST_LEN    = 16
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_axi_addr_i,
    input  logic [BRAM_ADDR_WIDTH-1:0]  cmd_bram_addr_i,
    input  logic [BYTE_TRANS_WIDTH-1:0] cmd_btt_i,
    output logic                        done_o,
    output logic                        err_o,

    dm_rd_responder_if.master           m_axi,

    output logic                        bram_en_o,
    output logic                        bram_we_o,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_addr_o,
    output logic [BRAM_DATA_WIDTH-1:0]  bram_din_o
`ifdef DM_RD_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_cycles_o
`endif
);

    localparam int BEATS_WIDTH = BYTE_TRANS_WIDTH - BEAT_SHIFT;

    dm_state_e                   state_q;
    logic                        cmd_ready_q;
    logic                        done_q;
    logic                        err_q;
    logic                        err_sticky_q;
    logic                        arvalid_q;
    logic [AXI_ADDR_WIDTH-1:0]   araddr_q;
    logic [7:0]                  arlen_q;
    logic                        rready_q;
    logic [BEATS_WIDTH-1:0]      beats_rem_q;
    logic [7:0]                  burst_cnt_q;
    logic [BRAM_ADDR_WIDTH-1:0]  wr_ptr_q;
    logic                        bram_en_q;
    logic [BRAM_ADDR_WIDTH-1:0]  bram_addr_q;
    logic [BRAM_DATA_WIDTH-1:0]  bram_din_q;

    logic [AXI_ADDR_WIDTH-1:0]   araddr_d;
    logic [BEATS_WIDTH-1:0]      beats_rem_d;
    logic [AXI_ADDR_WIDTH-1:0]   burst_bytes;
    logic [7:0]                  calc_arlen;
    logic                        accept;
    logic                        btt_bad;
    logic                        r_hs;
    logic                        burst_last;
    logic                        resp_err;
    logic                        rlast_err;

    assign accept     = cmd_valid_i && cmd_ready_q;
    assign btt_bad    = (cmd_btt_i == '0) || (cmd_btt_i[BEAT_SHIFT-1:0] != '0);
    assign r_hs       = m_axi.rvalid && rready_q;
    assign burst_last = (burst_cnt_q == 8'd0);
    assign resp_err   = (m_axi.rresp != AXI_RESP_OKAY);
    assign rlast_err  = (m_axi.rlast != burst_last);
    assign burst_bytes = AXI_ADDR_WIDTH'({arlen_q, {BEAT_SHIFT{1'b0}}})
                       + AXI_ADDR_WIDTH'(BEAT_BYTES);

    // Next address/beat count feed the burst sizer so arlen is registered together with arvalid.
    always_comb begin
        araddr_d    = araddr_q;
        beats_rem_d = beats_rem_q;
        if (state_q == IDLE) begin
            araddr_d    = cmd_axi_addr_i;
            beats_rem_d = cmd_btt_i[BYTE_TRANS_WIDTH-1:BEAT_SHIFT];
        end else if ((state_q == R) && r_hs) begin
            beats_rem_d = beats_rem_q - BEATS_WIDTH'(1);
            if (burst_last) begin
                araddr_d = araddr_q + burst_bytes;
            end
        end
    end

    dm_burst_calc #(
        .BEATS_WIDTH   (BEATS_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_burst_calc (
        .beats_rem_i (beats_rem_d),
        .addr_lo_i   (araddr_d[11:0]),
        .arlen_o     (calc_arlen)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            rready_q     <= 1'b0;
            beats_rem_q  <= '0;
            burst_cnt_q  <= '0;
            wr_ptr_q     <= '0;
            bram_en_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bram_en_q <= r_hs;
            if (r_hs) begin
                bram_din_q  <= m_axi.rdata;
                bram_addr_q <= wr_ptr_q;
                wr_ptr_q    <= wr_ptr_q + BRAM_ADDR_WIDTH'(1);
            end

            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        araddr_q    <= araddr_d;
                        beats_rem_q <= beats_rem_d;
                        wr_ptr_q    <= cmd_bram_addr_i;
                        if (btt_bad) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q   <= AR;
                            arvalid_q <= 1'b1;
                            arlen_q   <= calc_arlen;
                        end
                    end
                end
                AR: begin
                    if (m_axi.arready) begin
                        arvalid_q   <= 1'b0;
                        rready_q    <= 1'b1;
                        burst_cnt_q <= arlen_q;
                        state_q     <= R;
                    end
                end
                R: begin
                    if (r_hs) begin
                        beats_rem_q <= beats_rem_d;
                        burst_cnt_q <= burst_cnt_q - 8'd1;
                        if (resp_err || rlast_err) begin
                            err_sticky_q <= 1'b1;
                        end
                        if (burst_last) begin
                            araddr_q <= araddr_d;
                            rready_q <= 1'b0;
                            if (beats_rem_d == '0) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                err_q   <= err_sticky_q || resp_err || rlast_err;
                            end else begin
                                state_q   <= AR;
                                arvalid_q <= 1'b1;
                                arlen_q   <= calc_arlen;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    cmd_ready_q  <= 1'b1;
                    err_sticky_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef DM_RD_PERF_CNT_EN
    logic [31:0] perf_run_q;
    logic [31:0] perf_cycles_q;

    // perf_run_q counts cycles since accept, excluding the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_run_q    <= '0;
            perf_cycles_q <= '0;
        end else begin
            if (state_q == IDLE) begin
                if (accept) begin
                    perf_run_q <= 32'd1;
                end
            end else if (perf_run_q != '1) begin
                perf_run_q <= perf_run_q + 32'd1;
            end
            if (state_q == DONE) begin
                perf_cycles_q <= (perf_run_q == '1) ? '1 : perf_run_q + 32'd1;
            end
        end
    end

    assign perf_cycles_o = perf_cycles_q;
`endif

    assign cmd_ready_o     = cmd_ready_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign m_axi.arvalid   = arvalid_q;
    assign m_axi.araddr    = araddr_q;
    assign m_axi.arlen     = arlen_q;
    assign m_axi.arsize    = axi_size(BRAM_DATA_WIDTH);
    assign m_axi.arburst   = AXI_BURST_INCR;
    assign m_axi.arid      = '0;
    assign m_axi.rready    = rready_q;
    assign bram_en_o       = bram_en_q;
    assign bram_we_o       = bram_en_q;
    assign bram_addr_o     = bram_addr_q;
    assign bram_din_o      = bram_din_q;

endmodule

// File: tb/tb_dm_rd_responder.sv
// Directed bench for dm_rd_responder: AXI read slave model, BRAM monitor, hand-computed expectations.
module tb_dm_rd_responder;

    typedef struct {
        logic [35:0] addr;
        logic        last;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [35:0]   cmd_axi_addr_i;
    logic [9:0]    cmd_bram_addr_i;
    logic [14:0]   cmd_btt_i;
    logic          done_o;
    logic          err_o;
    logic          bram_en_o;
    logic          bram_we_o;
    logic [9:0]    bram_addr_o;
    logic [1023:0] bram_din_o;
`ifdef DM_RD_PERF_CNT_EN
    logic [31:0]   perf_cycles_o;
`endif

    dm_rd_responder_if #(.AXI_ADDR_WIDTH(36), .BRAM_DATA_WIDTH(1024), .AXI_ID_WIDTH(4)) axi ();

    dm_rd_responder dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_axi_addr_i  (cmd_axi_addr_i),
        .cmd_bram_addr_i (cmd_bram_addr_i),
        .cmd_btt_i       (cmd_btt_i),
        .done_o          (done_o),
        .err_o           (err_o),
        .m_axi           (axi),
        .bram_en_o       (bram_en_o),
        .bram_we_o       (bram_we_o),
        .bram_addr_o     (bram_addr_o),
        .bram_din_o      (bram_din_o)
`ifdef DM_RD_PERF_CNT_EN
        ,
        .perf_cycles_o   (perf_cycles_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1023:0] beat_data(input logic [35:0] a);
        return {16{28'hABCDEF1, a}};
    endfunction

    // ---------------- AXI read slave model ----------------
    beat_t       beat_q[$];
    beat_t       bt_tmp;
    logic [35:0] ar_addr_log[$];
    logic [7:0]  ar_len_log[$];
    bit          r_hs_nxt = 1'b0;
    bit          ar_hold  = 1'b0;
    bit          r_keep;
    logic [35:0] hold_addr;
    logic [7:0]  hold_len;
    int          ar_unstable = 0;
    int          beat_cnt    = 0;
    int          err_beat    = -1;
    int          stall_pct   = 0;

    // Drives at negedge; a handshake is known here and takes effect at the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            beat_q.delete();
            r_hs_nxt    = 1'b0;
            ar_hold     = 1'b0;
            axi.arready = 1'b0;
            axi.rvalid  = 1'b0;
            axi.rdata   = '0;
            axi.rresp   = 2'b00;
            axi.rlast   = 1'b0;
        end else begin
            r_keep = axi.rvalid && !r_hs_nxt;
            if (r_hs_nxt) begin
                beat_q.delete(0);
                beat_cnt++;
            end
            if (beat_q.size() != 0 && (r_keep || int'($urandom_range(0, 99)) >= stall_pct)) begin
                axi.rvalid = 1'b1;
                axi.rdata  = beat_data(beat_q[0].addr);
                axi.rlast  = beat_q[0].last;
                axi.rresp  = (beat_cnt == err_beat) ? 2'b10 : 2'b00;
            end else begin
                axi.rvalid = 1'b0;
            end
            r_hs_nxt = axi.rvalid && axi.rready;

            if (ar_hold && (!axi.arvalid || axi.araddr != hold_addr || axi.arlen != hold_len))
                ar_unstable++;
            axi.arready = (int'($urandom_range(0, 99)) >= stall_pct);
            if (axi.arvalid && axi.arready) begin
                ar_addr_log.push_back(axi.araddr);
                ar_len_log.push_back(axi.arlen);
                for (int i = 0; i <= int'(axi.arlen); i++) begin
                    bt_tmp.addr = axi.araddr + 36'(i * 128);
                    bt_tmp.last = (i == int'(axi.arlen));
                    beat_q.push_back(bt_tmp);
                end
                ar_hold = 1'b0;
            end else begin
                ar_hold   = axi.arvalid;
                hold_addr = axi.araddr;
                hold_len  = axi.arlen;
            end
        end
    end

    // ---------------- BRAM / done monitor ----------------
    logic [1023:0] bram_mem [0:1023];
    int  wr_cnt = 0, we_bad = 0, done_cnt = 0, done_wide = 0, wr_at_done = 0, done_cyc = 0;
    bit  done_prev = 1'b0;
    logic last_err;

    always @(negedge clk) begin
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (bram_en_o) begin
                if (bram_we_o !== 1'b1) we_bad++;
                bram_mem[bram_addr_o] = bram_din_o;
                wr_cnt++;
            end
            if (done_o) begin
                if (done_prev) done_wide++;
                done_cnt++;
                last_err   = err_o;
                wr_at_done = wr_cnt;
                done_cyc   = cyc;
            end
            done_prev = done_o;
        end
    end

    // ---------------- stimulus helpers ----------------
    int acc_cyc;

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready_o, 1);
        chk({tag, "_done"},      done_o, 0);
        chk({tag, "_err"},       err_o, 0);
        chk({tag, "_arvalid"},   axi.arvalid, 0);
        chk({tag, "_rready"},    axi.rready, 0);
        chk({tag, "_bram_en"},   bram_en_o, 0);
        chk({tag, "_bram_we"},   bram_we_o, 0);
        chk({tag, "_araddr"},    axi.araddr, 0);
        chk({tag, "_arlen"},     axi.arlen, 0);
        chk({tag, "_bram_addr"}, bram_addr_o, 0);
        chk({tag, "_bram_din0"}, (bram_din_o == '0), 1);
    endtask

    task automatic issue(input logic [35:0] a, input logic [9:0] b, input logic [14:0] n);
        int g;
        g = 0;
        cmd_valid_i     = 1'b1;
        cmd_axi_addr_i  = a;
        cmd_bram_addr_i = b;
        cmd_btt_i       = n;
        while (cmd_ready_o !== 1'b1 && g < 200) begin
            @(posedge clk); #2;
            g++;
        end
        if (g >= 200) chk("cmd_accept_timeout", 0, 1);
        acc_cyc = cyc;
        @(posedge clk); #2;
        cmd_valid_i = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic [35:0] a, input logic [9:0] b,
                        input logic [14:0] n, input logic exp_err, input int nb, output int ar0);
        int wr0, d0, g, bad;
        wr0 = wr_cnt;
        d0  = done_cnt;
        ar0 = ar_addr_log.size();
        issue(a, b, n);
        g = 0;
        while (done_cnt == d0 && g < 5000) begin
            @(posedge clk); #2;
            g++;
        end
        if (done_cnt == d0) chk({tag, "_done_timeout"}, 0, 1);
        repeat (2) @(posedge clk);
        #2;
        chk({tag, "_err"},         last_err, exp_err);
        chk({tag, "_writes"},      wr_cnt - wr0, nb);
        chk({tag, "_wr_at_done"},  wr_at_done - wr0, nb);
        chk({tag, "_done_width"},  done_wide, 0);
        if (nb > 0) begin
            bad = 0;
            for (int i = 0; i < nb; i++)
                if (bram_mem[10'(int'(b) + i)] !== beat_data(a + 36'(i * 128))) bad++;
            chk({tag, "_data_bad"}, bad, 0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int ar0, g, wr0, d0;
        rst             = 1'b1;
        cmd_valid_i     = 1'b0;
        cmd_axi_addr_i  = '0;
        cmd_bram_addr_i = '0;
        cmd_btt_i       = '0;
        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs("reset");
        rst = 1'b0;
        chk("arsize", axi.arsize, 7);
        chk("arburst", axi.arburst, 1);
        chk("arid", axi.arid, 0);
        repeat (2) @(posedge clk);
        #2;

        // Single full burst
        xfer("t1", 36'h0_0000_0000, 10'h000, 15'd2048, 1'b0, 16, ar0);
        chk("t1_ar_cnt",  ar_addr_log.size() - ar0, 1);
        chk("t1_ar_addr", ar_addr_log[ar0], 36'h0);
        chk("t1_ar_len",  ar_len_log[ar0], 15);
`ifdef DM_RD_PERF_CNT_EN
        chk("t1_perf", perf_cycles_o, done_cyc - acc_cyc + 1);
`endif

        // Split at the 4 KB boundary
        xfer("t2", 36'h0_0000_0F00, 10'h020, 15'd1024, 1'b0, 8, ar0);
        chk("t2_ar_cnt",   ar_addr_log.size() - ar0, 2);
        chk("t2_ar0_addr", ar_addr_log[ar0], 36'hF00);
        chk("t2_ar0_len",  ar_len_log[ar0], 1);
        chk("t2_ar1_addr", ar_addr_log[ar0 + 1], 36'h1000);
        chk("t2_ar1_len",  ar_len_log[ar0 + 1], 5);

        // Rejected byte counts
        xfer("bad100", 36'h0_0000_8000, 10'h000, 15'd100, 1'b1, 0, ar0);
        chk("bad100_latency", done_cyc - acc_cyc, 1);
        chk("bad100_no_ar",   ar_addr_log.size() - ar0, 0);
`ifdef DM_RD_PERF_CNT_EN
        chk("bad100_perf", perf_cycles_o, 2);
`endif
        xfer("bad0", 36'h0_0000_8000, 10'h000, 15'd0, 1'b1, 0, ar0);
        chk("bad0_latency", done_cyc - acc_cyc, 1);
        chk("bad0_no_ar",   ar_addr_log.size() - ar0, 0);

        // 255 beats, BRAM address wraps 0x3FF -> 0x000
        xfer("wrap", 36'h1_0000_0000, 10'h3F8, 15'd32640, 1'b0, 255, ar0);
        chk("wrap_ar_cnt", ar_addr_log.size() - ar0, 16);
        g = 0;
        for (int k = 0; k < 16; k++) begin
            if (ar_addr_log[ar0 + k] !== 36'h1_0000_0000 + 36'(k * 2048)) g++;
            if (ar_len_log[ar0 + k] !== ((k < 15) ? 8'd15 : 8'd14)) g++;
        end
        chk("wrap_ar_list_bad", g, 0);
        chk("wrap_bram0", (bram_mem[0] == beat_data(36'h1_0000_0400)), 1);

        // Stalls plus SLVERR on beat 3
        stall_pct = 40;
        err_beat  = beat_cnt + 3;
        xfer("slverr", 36'h2_0000_0000, 10'h100, 15'd5120, 1'b1, 40, ar0);
        err_beat  = -1;
        chk("slverr_ar_cnt",   ar_addr_log.size() - ar0, 3);
        chk("slverr_ar1_addr", ar_addr_log[ar0 + 1], 36'h2_0000_0800);
        chk("slverr_ar2_addr", ar_addr_log[ar0 + 2], 36'h2_0000_1000);
        chk("slverr_ar2_len",  ar_len_log[ar0 + 2], 7);
        chk("ar_stable_violations", ar_unstable, 0);
        xfer("after_err", 36'h0_0000_3000, 10'h200, 15'd512, 1'b0, 4, ar0);
        stall_pct = 0;

        // Reset in the middle of a burst
        wr0 = wr_cnt;
        d0  = done_cnt;
        issue(36'h0_0000_4000, 10'h080, 15'd2048);
        g = 0;
        while (wr_cnt - wr0 < 4 && g < 200) begin
            @(posedge clk); #2;
            g++;
        end
        chk("mid_reached_burst", (wr_cnt - wr0 >= 4), 1);
        rst = 1'b1;
        @(posedge clk); #2;
        check_idle_outputs("mid_rst");
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("mid_no_done", done_cnt - d0, 0);
        xfer("post_rst", 36'h0_0000_5000, 10'h040, 15'd1024, 1'b0, 8, ar0);
        chk("post_rst_ar_cnt", ar_addr_log.size() - ar0, 1);
        chk("post_rst_ar_len", ar_len_log[ar0], 7);
        chk("we_with_en", we_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
